// File: rtl/cpu_tg_pkg.sv
// Shared definitions for the CPU-port traffic generator: cpustate access
// codes, mode codes, controller state enum, LFSR taps and default seed/key.
// Imported by cpu_traffic_gen and tg_lfsr.
package cpu_tg_pkg;

   // cpustate[1:0] access codes seen by sdram_ctrl
   localparam logic [1:0] ST_NONE  = 2'b01;
   localparam logic [1:0] ST_READ  = 2'b10;
   localparam logic [1:0] ST_WRITE = 2'b11;

   // Pattern modes
   localparam logic [1:0] MODE_SEQ  = 2'd0;
   localparam logic [1:0] MODE_LFSR = 2'd1;
   localparam logic [1:0] MODE_BYTE = 2'd2;
   localparam logic [1:0] MODE_LONG = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_WR_WAIT,
      S_RD,
      S_RD_WAIT,
      S_DONE
   } tg_state_e;

   localparam logic [31:0] DEF_LFSR_SEED = 32'hACE1_2468;
   localparam logic [15:0] DEF_DATA_KEY  = 16'h5A3C;

   // Galois right-shift feedback mask for x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/tg_lfsr.sv
// 32-bit Galois LFSR (taps 32,22,2,1) used as the address scrambler.
// Ports: clk_i/reset_i (sync, active-high), load_i reseeds, step_i advances one
// position (load wins), state_o exposes the low OUT_W bits of the register.
module tg_lfsr
   import cpu_tg_pkg::*;
#(
   parameter logic [31:0] SEED  = DEF_LFSR_SEED,
   parameter int          OUT_W = 32
)(
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic             step_i,
   output logic [OUT_W-1:0] state_o
);

   logic [31:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = SEED;
      end else if (step_i) begin
         lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/cpu_traffic_gen.sv
// CPU-side traffic generator/checker for the sdram_ctrl CPU port: a write pass
// over a region, then a read-back pass checked against the regenerated pattern.
// Ports: start/mode/base_addr/length program a run; ena28/cpuena/cpuRD come
// from sdram_ctrl; cpuAddr/cpustate/cpuL/cpuU/cpuWR drive it; busy/done/
// err_cnt/first_err_addr report status. Sync active-high reset on clk_114.
module cpu_traffic_gen
   import cpu_tg_pkg::*;
#(
   parameter int          ADDR_W    = 24,
   parameter int          LEN_W     = 16,
   parameter int          ERR_W     = 16,
   parameter logic [31:0] LFSR_SEED = DEF_LFSR_SEED,
   parameter logic [15:0] DATA_KEY  = DEF_DATA_KEY
)(
   input  logic              clk_114,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W:1]   base_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic              ena28,
   input  logic              cpuena,
   input  logic [15:0]       cpuRD,
   output logic [ADDR_W:1]   cpuAddr,
   output logic [6:0]        cpustate,
   output logic              cpuL,
   output logic              cpuU,
   output logic [15:0]       cpuWR,
   output logic              busy,
   output logic              done,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [ADDR_W:1]   first_err_addr
);

   tg_state_e         state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [ADDR_W:1]   base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic              half_q, half_d;    // second word of a longword access
   logic [ADDR_W:1]   addr_q, addr_d;
   logic [15:0]       wdat_q, wdat_d;
   logic [1:0]        st_q, st_d;
   logic              ncs_q, ncs_d;
   logic              lw_q, lw_d;
   logic              l_q, l_d;
   logic              u_q, u_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [ADDR_W:1]   ferr_q, ferr_d;

   logic              lfsr_load, lfsr_step;
   logic [ADDR_W-1:0] lfsr_bits;

   tg_lfsr #(.SEED(LFSR_SEED), .OUT_W(ADDR_W)) u_lfsr (
      .clk_i   (clk_114),
      .reset_i (reset),
      .load_i  (lfsr_load),
      .step_i  (lfsr_step),
      .state_o (lfsr_bits)
   );

   // Pattern for the access at idx_q/half_q. Both passes call this with the
   // same index and LFSR history, so reads regenerate the written sequence.
   logic [ADDR_W:1] gen_addr, lw_first;
   logic [15:0]     gen_dat, lw_dat;
   logic            gen_l, gen_u;

   always_comb begin
      lw_first = base_q + ADDR_W'({idx_q, 1'b0});
      lw_dat   = 16'(lw_first) ^ DATA_KEY;
      gen_addr = base_q + ADDR_W'(idx_q);
      gen_l    = 1'b0;
      gen_u    = 1'b0;
      case (mode_q)
         MODE_LFSR: gen_addr = base_q ^ lfsr_bits;
         MODE_LONG: gen_addr = lw_first + ADDR_W'(half_q);
         MODE_BYTE: begin
            gen_l = idx_q[0];
            gen_u = ~idx_q[0];
         end
         default: ;
      endcase
      gen_dat = 16'(gen_addr) ^ DATA_KEY;
      if (mode_q == MODE_LONG) begin
         gen_dat = half_q ? ~lw_dat : lw_dat;
      end
   end

   logic        access_done, last, mismatch, is_wr;
   logic [15:0] lane_mask;

   assign access_done = ena28 && cpuena;
   assign last        = (idx_q == len_q - LEN_W'(1));
   // Only the byte lanes actually enabled on this access are compared
   assign lane_mask   = {{8{~u_q}}, {8{~l_q}}};
   assign mismatch    = |((cpuRD ^ wdat_q) & lane_mask);
   assign is_wr       = (state_q == S_WR) || (state_q == S_WR_WAIT);

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      base_d    = base_q;
      len_d     = len_q;
      idx_d     = idx_q;
      half_d    = half_q;
      addr_d    = addr_q;
      wdat_d    = wdat_q;
      st_d      = st_q;
      ncs_d     = ncs_q;
      lw_d      = lw_q;
      l_d       = l_q;
      u_d       = u_q;
      err_d     = err_q;
      ferr_d    = ferr_q;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (length == '0) begin
                  state_d = S_DONE;
               end else begin
                  mode_d    = mode;
                  base_d    = base_addr;
                  len_d     = length;
                  idx_d     = '0;
                  half_d    = 1'b0;
                  err_d     = '0;
                  ferr_d    = '0;
                  lfsr_load = 1'b1;
                  state_d   = S_WR;
               end
            end
         end

         // Issue cycle: outputs are still idle here (this is the mandatory
         // gap after a completion); the request registers load on its edge.
         S_WR, S_RD: begin
            addr_d  = gen_addr;
            wdat_d  = gen_dat;
            l_d     = gen_l;
            u_d     = gen_u;
            lw_d    = (mode_q == MODE_LONG);
            ncs_d   = 1'b0;
            st_d    = is_wr ? ST_WRITE : ST_READ;
            state_d = is_wr ? S_WR_WAIT : S_RD_WAIT;
         end

         S_WR_WAIT, S_RD_WAIT: begin
            if (access_done) begin
               st_d  = ST_NONE;
               ncs_d = 1'b1;
               l_d   = 1'b1;
               u_d   = 1'b1;
               lw_d  = 1'b0;
               if (!is_wr && mismatch) begin
                  if (err_q != '1) begin
                     err_d = err_q + ERR_W'(1);
                  end
                  if (err_q == '0) begin
                     ferr_d = addr_q;
                  end
               end
               if (mode_q == MODE_LONG && !half_q) begin
                  half_d  = 1'b1;
                  state_d = is_wr ? S_WR : S_RD;
               end else begin
                  half_d = 1'b0;
                  if (last) begin
                     idx_d     = '0;
                     lfsr_load = 1'b1;
                     state_d   = is_wr ? S_RD : S_DONE;
                  end else begin
                     idx_d     = idx_q + LEN_W'(1);
                     lfsr_step = 1'b1;
                     state_d   = is_wr ? S_WR : S_RD;
                  end
               end
            end
         end

         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_114) begin
      if (reset) begin
         state_q <= S_IDLE;
         mode_q  <= MODE_SEQ;
         base_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         half_q  <= 1'b0;
         addr_q  <= '0;
         wdat_q  <= '0;
         st_q    <= ST_NONE;
         ncs_q   <= 1'b1;
         lw_q    <= 1'b0;
         l_q     <= 1'b1;
         u_q     <= 1'b1;
         err_q   <= '0;
         ferr_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         base_q  <= base_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         half_q  <= half_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         st_q    <= st_d;
         ncs_q   <= ncs_d;
         lw_q    <= lw_d;
         l_q     <= l_d;
         u_q     <= u_d;
         err_q   <= err_d;
         ferr_q  <= ferr_d;
      end
   end

   assign cpuAddr        = addr_q;
   assign cpustate       = {lw_q, 3'b000, ncs_q, st_q};
   assign cpuL           = l_q;
   assign cpuU           = u_q;
   assign cpuWR          = wdat_q;
   assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done           = (state_q == S_DONE);
   assign err_cnt        = err_q;
   assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_cpu_traffic_gen.sv
module tb_cpu_traffic_gen;

   logic        clk_114 = 1'b0;
   logic        reset, start;
   logic [1:0]  mode;
   logic [24:1] base_addr;
   logic [15:0] length;
   logic        ena28, cpuena;
   logic [15:0] cpuRD;
   logic [24:1] cpuAddr;
   logic [6:0]  cpustate;
   logic        cpuL, cpuU;
   logic [15:0] cpuWR;
   logic        busy, done;
   logic [15:0] err_cnt;
   logic [24:1] first_err_addr;

   cpu_traffic_gen dut (
      .clk_114(clk_114), .reset(reset), .start(start), .mode(mode),
      .base_addr(base_addr), .length(length), .ena28(ena28), .cpuena(cpuena),
      .cpuRD(cpuRD), .cpuAddr(cpuAddr), .cpustate(cpustate), .cpuL(cpuL),
      .cpuU(cpuU), .cpuWR(cpuWR), .busy(busy), .done(done),
      .err_cnt(err_cnt), .first_err_addr(first_err_addr)
   );

   always #5 clk_114 = ~clk_114;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- SDRAM responder (ideal memory + fault hooks) -----------
   int          lat = 0;
   logic [24:1] flt_addr = '1;
   logic [15:0] flt_xor = 16'h0;
   logic [15:0] flt_even_xor = 16'h0;
   logic [15:0] mem [logic [24:1]];
   logic [24:1] wr_a[$];
   logic [15:0] wr_d[$];
   logic [1:0]  wr_lu[$];
   logic        wr_lw[$];
   logic [24:1] rd_a[$];
   int          wcnt = 0, done_cnt = 0, stab_err = 0;
   logic [24:1] p_addr;
   logic [6:0]  p_st;
   logic [15:0] p_wr, rdv;
   logic [1:0]  p_lu;

   always @(negedge clk_114) begin
      ena28 = 1'b0;
      cpuena = 1'b0;
      cpuRD = 16'hDEAD;
      if (done === 1'b1) done_cnt++;
      if (reset === 1'b1 || cpustate[2] !== 1'b0) begin
         wcnt = 0;
      end else begin
         if (wcnt == 0) begin
            p_addr = cpuAddr; p_st = cpustate; p_wr = cpuWR; p_lu = {cpuU, cpuL};
         end else if (cpuAddr !== p_addr || cpustate !== p_st || cpuWR !== p_wr ||
                      {cpuU, cpuL} !== p_lu) begin
            stab_err++;
         end
         if (wcnt >= lat) begin
            ena28 = 1'b1;
            cpuena = 1'b1;
            wcnt = 0;
            rdv = mem.exists(cpuAddr) ? mem[cpuAddr] : 16'h0000;
            if (cpustate[1:0] == 2'b11) begin
               if (!cpuL) rdv[7:0] = cpuWR[7:0];
               if (!cpuU) rdv[15:8] = cpuWR[15:8];
               mem[cpuAddr] = rdv;
               wr_a.push_back(cpuAddr);
               wr_d.push_back(cpuWR);
               wr_lu.push_back({cpuU, cpuL});
               wr_lw.push_back(cpustate[6]);
            end else begin
               if (cpuAddr == flt_addr) rdv = rdv ^ flt_xor;
               if (!cpuAddr[1]) rdv = rdv ^ flt_even_xor;
               cpuRD = rdv;
               rd_a.push_back(cpuAddr);
            end
         end else begin
            wcnt++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------------------------------
   task automatic kick(input logic [1:0] m, input logic [24:1] b, input logic [15:0] l);
      @(negedge clk_114);
      mode = m; base_addr = b; length = l; start = 1'b1;
      @(negedge clk_114);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk_114);
         n++;
      end
      check(tag, 32'(done), 32'(1));
      check({tag, "_busy"}, 32'(busy), 32'(0));
   endtask

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   logic [24:1] exp_a;
   logic [24:1] tbl_a [4];
   logic [15:0] tbl_d [4];
   logic [31:0] lf;
   int w0, r0, d0, found;

   initial begin
      reset = 1'b1; start = 1'b0; mode = 2'd0; base_addr = '0; length = '0;
      repeat (3) @(negedge clk_114);

      // ---- reset state ----
      check("rst_cpustate", 32'(cpustate), 32'h05);
      check("rst_cpuL", 32'(cpuL), 32'(1));
      check("rst_cpuU", 32'(cpuU), 32'(1));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_err", 32'(err_cnt), 32'(0));
      check("rst_ferr", 32'(first_err_addr), 32'(0));
      reset = 1'b0;
      @(negedge clk_114);
      check("idle_cpustate", 32'(cpustate), 32'h05);

      // ---- T1: sequential, base 0x100, len 16 ----
      lat = 1; w0 = wr_a.size(); r0 = rd_a.size(); d0 = done_cnt;
      kick(2'd0, 24'h000100, 16'd16);
      check("t1_gap_state", 32'(cpustate), 32'h05);
      @(negedge clk_114);
      check("t1_first_state", 32'(cpustate), 32'h03);
      check("t1_first_addr", 32'(cpuAddr), 32'h100);
      check("t1_first_data", 32'(cpuWR), 32'h5B3C);
      check("t1_busy", 32'(busy), 32'(1));
      wait_done("t1_done", 1000);
      check("t1_err", 32'(err_cnt), 32'(0));
      repeat (3) @(negedge clk_114);
      check("t1_done_once", 32'(done_cnt - d0), 32'(1));
      check("t1_nwr", 32'(wr_a.size() - w0), 32'(16));
      check("t1_nrd", 32'(rd_a.size() - r0), 32'(16));
      for (int k = 0; k < 16 && w0 + k < wr_a.size() && r0 + k < rd_a.size(); k++) begin
         exp_a = 24'h000100 + 24'(k);
         check("t1_wr_addr", 32'(wr_a[w0+k]), 32'(exp_a));
         check("t1_wr_data", 32'(wr_d[w0+k]), 32'(exp_a[16:1] ^ 16'h5A3C));
         check("t1_wr_lanes", 32'(wr_lu[w0+k]), 32'(0));
         check("t1_rd_addr", 32'(rd_a[r0+k]), 32'(exp_a));
      end

      // ---- T2: LFSR, len 64 ----
      lat = 0; w0 = wr_a.size(); r0 = rd_a.size();
      kick(2'd1, 24'h00F0F0, 16'd64);
      wait_done("t2_done", 2000);
      check("t2_err", 32'(err_cnt), 32'(0));
      check("t2_nwr", 32'(wr_a.size() - w0), 32'(64));
      check("t2_nrd", 32'(rd_a.size() - r0), 32'(64));
      if (wr_a.size() > w0) check("t2_first_addr", 32'(wr_a[w0]), 32'hE1D498);
      lf = 32'hACE1_2468;
      for (int k = 0; k < 64 && w0 + k < wr_a.size() && r0 + k < rd_a.size(); k++) begin
         check("t2_wr_addr", 32'(wr_a[w0+k]), 32'(24'h00F0F0 ^ lf[23:0]));
         check("t2_rd_eq_wr", 32'(rd_a[r0+k]), 32'(wr_a[w0+k]));
         lf = lfsr_next(lf);
      end

      // ---- T3: sequential len 8, bit 0 flipped on read at 0x104 ----
      lat = 2; flt_addr = 24'h000104; flt_xor = 16'h0001;
      kick(2'd0, 24'h000100, 16'd8);
      wait_done("t3_done", 1000);
      check("t3_err", 32'(err_cnt), 32'(1));
      check("t3_ferr", 32'(first_err_addr), 32'h104);
      flt_addr = '1; flt_xor = 16'h0;

      // ---- T4: byte-lane len 4, upper byte corrupted at even addresses ----
      lat = 1; w0 = wr_a.size(); flt_even_xor = 16'hFF00;
      kick(2'd2, 24'h000200, 16'd4);
      wait_done("t4_done", 500);
      check("t4_err", 32'(err_cnt), 32'(0));
      if (wr_a.size() >= w0 + 2) begin
         check("t4_lane_even", 32'(wr_lu[w0]), 32'(2'b10));
         check("t4_lane_odd", 32'(wr_lu[w0+1]), 32'(2'b01));
      end
      // lower (checked) lane corrupted at even addresses: i=0 and i=2 fail
      flt_even_xor = 16'h0001;
      kick(2'd2, 24'h000200, 16'd4);
      wait_done("t4b_done", 500);
      check("t4b_err", 32'(err_cnt), 32'(2));
      check("t4b_ferr", 32'(first_err_addr), 32'h200);
      flt_even_xor = 16'h0;

      // ---- T5: address wrap ----
      lat = 0; w0 = wr_a.size();
      tbl_a = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
      tbl_d = '{16'hA5C2, 16'hA5C3, 16'h5A3C, 16'h5A3D};
      kick(2'd0, 24'hFFFFFE, 16'd4);
      wait_done("t5_done", 500);
      check("t5_err", 32'(err_cnt), 32'(0));
      for (int k = 0; k < 4 && w0 + k < wr_a.size(); k++) begin
         check("t5_wr_addr", 32'(wr_a[w0+k]), 32'(tbl_a[k]));
         check("t5_wr_data", 32'(wr_d[w0+k]), 32'(tbl_d[k]));
      end

      // ---- T6: longword len 2 (two words per longword) ----
      lat = 1; w0 = wr_a.size(); r0 = rd_a.size();
      tbl_a = '{24'h000300, 24'h000301, 24'h000302, 24'h000303};
      tbl_d = '{16'h593C, 16'hA6C3, 16'h593E, 16'hA6C1};
      kick(2'd3, 24'h000300, 16'd2);
      wait_done("t6_done", 500);
      check("t6_err", 32'(err_cnt), 32'(0));
      check("t6_nrd", 32'(rd_a.size() - r0), 32'(4));
      for (int k = 0; k < 4 && w0 + k < wr_a.size(); k++) begin
         check("t6_wr_addr", 32'(wr_a[w0+k]), 32'(tbl_a[k]));
         check("t6_wr_data", 32'(wr_d[w0+k]), 32'(tbl_d[k]));
         check("t6_longword", 32'(wr_lw[w0+k]), 32'(1));
      end

      // ---- T7: reset during RD_WAIT, then a normal run ----
      lat = 3; found = 0;
      kick(2'd0, 24'h000400, 16'd4);
      for (int n = 0; n < 300 && found == 0; n++) begin
         if (cpustate[2:0] == 3'b010) found = 1;
         else @(negedge clk_114);
      end
      check("t7_reached_rd_wait", 32'(found), 32'(1));
      d0 = done_cnt;
      reset = 1'b1;
      @(negedge clk_114);
      check("t7_rst_cpustate", 32'(cpustate), 32'h05);
      check("t7_rst_busy", 32'(busy), 32'(0));
      check("t7_rst_lanes", 32'({cpuU, cpuL}), 32'(2'b11));
      reset = 1'b0;
      lat = 1; w0 = wr_a.size(); r0 = rd_a.size();
      kick(2'd0, 24'h000500, 16'd2);
      wait_done("t7_done", 500);
      check("t7_err", 32'(err_cnt), 32'(0));
      repeat (3) @(negedge clk_114);
      check("t7_nwr", 32'(wr_a.size() - w0), 32'(2));
      check("t7_nrd", 32'(rd_a.size() - r0), 32'(2));
      check("t7_done_cnt", 32'(done_cnt - d0), 32'(1));

      // ---- T8: length 0 -> done next cycle, no access ----
      w0 = wr_a.size(); r0 = rd_a.size();
      kick(2'd0, 24'h000600, 16'd0);
      check("t8_done", 32'(done), 32'(1));
      check("t8_busy", 32'(busy), 32'(0));
      @(negedge clk_114);
      check("t8_done_drop", 32'(done), 32'(0));
      repeat (4) @(negedge clk_114);
      check("t8_cpustate", 32'(cpustate), 32'h05);
      check("t8_no_access", 32'((wr_a.size() - w0) + (rd_a.size() - r0)), 32'(0));

      check("stable_requests", 32'(stab_err), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_traffic_gen.md
# cpu_traffic_gen

Parametrised synthesizable CPU-side traffic generator and checker for the `sdram_ctrl` CPU port; the successor to the hand-driven fake-CPU shim used in the CPU/cache/SDRAM Verilator bench.
- Issues a programmable write pass over a region, then a read-back pass, through the same `cpustate`/`cpuena` handshake the TG68 uses, and checks every returned word against a regenerated pattern.
- Supports sequential, pseudo-random, byte-lane and longword modes.
- Counts mismatches, so it runs on hardware as well as in simulation.

## Interface
- ADDR_W, 24: CPU word-address width; addresses are [ADDR_W:1].
- LEN_W, 16: width of the transfer-count register.
- ERR_W, 16: width of the saturating error counter.
- LFSR_SEED, 32'hACE1_2468: LFSR seed; must be nonzero.
- DATA_KEY, 16'h5A3C: constant XORed into generated data.

Ports:
- clk_114  in  1  system clock, same as `sdram_ctrl` sysclk.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; ignored while busy.
- mode  in  2  0 sequential, 1 LFSR-random, 2 byte-lane, 3 longword.
- base_addr  in  ADDR_W  first word address.
- length  in  LEN_W  number of accesses per pass.
- ena28  in  1  `enaWRreg` from `sdram_ctrl`.
- cpuena  in  1  `cpuena` from `sdram_ctrl`.
- cpuRD  in  16  `cpuRD` from `sdram_ctrl`.
- cpuAddr  out  ADDR_W  drives `cpuAddr`.
- cpustate  out  7  {longword, 3'b000, ncs, state[1:0]}.
- cpuL, cpuU  out  1 each  active-low byte enables.
- cpuWR  out  16  write data.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of the read pass.
- err_cnt  out  ERR_W  mismatch count, saturating.
- first_err_addr  out  ADDR_W  address of the first mismatch.

## Operation
- state[1:0] codes: 2'b01 no access, 2'b10 data read, 2'b11 write.
- Idle outputs: state=01, ncs=1, cpuL=cpuU=1, longword=0.
- FSM states: IDLE → WR → WR_WAIT → RD → RD_WAIT → (next or DONE) → IDLE.
- On start with length≠0:
  - latch mode, base_addr and length;
  - clear err_cnt and first_err_addr; reseed the LFSR;
  - go to WR.
- On start with length=0: done pulses the next cycle, with no accesses.
- WR/RD: present address, data and enables with ncs=0, then wait.
- WAIT: the access completes on the first cycle where ena28 && cpuena. Then:
  - advance the index;
  - drop back to state=01, ncs=1 for one cycle;
  - issue the next access.
- After `length` writes: reset index and LFSR to their start values and run RD. Address order is identical in both passes.
- Address generation:
  - sequential: base_addr + i, modulo 2^ADDR_W;
  - LFSR: base_addr XOR lfsr[ADDR_W-1:0];
  - longword: base_addr + 2i with longword=1.
- Data: cpuWR = addr[16:1] XOR DATA_KEY. In longword mode the second word is the complement of the first.
- Byte-lane mode:
  - even i: cpuL=0, cpuU=1;
  - odd i: cpuU=0, cpuL=1;
  - reads compare only the enabled lane.
- Check: at RD completion, compare cpuRD with the regenerated data.
  - On mismatch, increment err_cnt (saturating at all-ones).
  - On the first mismatch, latch first_err_addr.

## Timing
- Reset: all outputs take their idle values; busy=0, done=0, err_cnt=0, first_err_addr=0.
- Reset mid-transfer aborts on the same edge. No partial access is held.
- Request signals are stable from issue until the completion cycle; they change only on the cycle after completion.
- Minimum access spacing is 2 cycles (completion cycle + idle cycle).
- busy falls in the same cycle that done pulses.
- cpuRD is sampled exactly on the completion cycle.

## Structure
- Package `cpu_tg_pkg`: state[1:0] encodings, mode codes, FSM state enum, default seed and key.
- Sub-module `tg_lfsr`: 32-bit Galois LFSR (taps 32,22,2,1) with load and step inputs.
- Pattern generation and checking stay inline.

## Test plan
- Sequential, base=0x000100, length=16, ideal SDRAM model → 16 writes then 16 reads at 0x100..0x10F; done pulses once; err_cnt=0.
- LFSR mode, length=64 → read address sequence identical to write sequence; err_cnt=0.
- Sequential, length=8, with a fault that flips bit 0 of the read at 0x000104 → err_cnt=1, first_err_addr=0x000104.
- Byte-lane, length=4, with the upper byte corrupted at even addresses → err_cnt=0, because only the lower lane is checked on even accesses.
- base=0xFFFFFE, length=4 → addresses FFFFFE, FFFFFF, 000000, 000001.
- Reset asserted during RD_WAIT → next cycle: state=01, ncs=1, busy=0; a subsequent start runs normally. Also: start with length=0 → done one cycle later, no access.
